// File: rtl/lgdst_ts_spi_bridge.sv
// Deserializes a TS bit stream into a byte FIFO drained by an SPI mode-0 host; every async input is
// oversampled on clk. A byte is pushed 1 clk after its 8th bit; a push into a full FIFO is dropped and counted.
module lgdst_ts_spi_bridge #(
  parameter int         FIFO_AW      = 4,
  parameter bit         TS_MSB_FIRST = 1'b0,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] CLR_CMD      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ts_clk,
  input  logic               ts_d0,
  input  logic               ts_valid,
  input  logic               ts_sync,
  input  logic               spi_spck,
  input  logic               spi_npcs0,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ovf_flag,
  output logic [7:0]         drop_cnt
);

  localparam int               SS       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {SPI_IDLE, SPI_XFER} spi_st_e;

  // Edge chains {spi_npcs0, spi_spck, ts_clk} and level chains {spi_mosi, ts_sync, ts_valid, ts_d0}
  logic [2:0] esync_q [SS];
  logic [3:0] lsync_q [SS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) begin
        esync_q[i] <= 3'b100;
        lsync_q[i] <= 4'b0000;
      end
    end else begin
      esync_q[0] <= {spi_npcs0, spi_spck, ts_clk};
      lsync_q[0] <= {spi_mosi, ts_sync, ts_valid, ts_d0};
      for (int i = 1; i < SS; i++) begin
        esync_q[i] <= esync_q[i-1];
        lsync_q[i] <= lsync_q[i-1];
      end
    end
  end

  logic [2:0] e_new, e_old;
  logic [3:0] lvl_s;
  logic       ts_rise, sck_rise, sck_fall, cs_rise, cs_fall;
  logic       ts_din, ts_vld, ts_syn, mosi_s;

  assign e_new    = esync_q[SS-2];
  assign e_old    = esync_q[SS-1];
  assign lvl_s    = lsync_q[SS-1];
  assign ts_rise  = e_new[0] & ~e_old[0];
  assign sck_rise = e_new[1] & ~e_old[1];
  assign sck_fall = ~e_new[1] & e_old[1];
  assign cs_rise  = e_new[2] & ~e_old[2];
  assign cs_fall  = ~e_new[2] & e_old[2];
  assign ts_din   = lvl_s[0];
  assign ts_vld   = lvl_s[1];
  assign ts_syn   = lvl_s[2];
  assign mosi_s   = lvl_s[3];

  // ---------------- TS deserializer ----------------
  logic       ts_act_q;
  logic [2:0] ts_cnt_q;
  logic [7:0] ts_sh_q;
  logic       push_q;
  logic [7:0] push_dat_q;
  logic [2:0] ts_pos;
  logic [7:0] ts_cap, ts_first;

  assign ts_pos   = TS_MSB_FIRST ? ~ts_cnt_q : ts_cnt_q;
  assign ts_first = TS_MSB_FIRST ? {ts_din, 7'b0} : {7'b0, ts_din};

  always_comb begin
    ts_cap         = ts_sh_q;
    ts_cap[ts_pos] = ts_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_act_q   <= 1'b0;
      ts_cnt_q   <= 3'd0;
      ts_sh_q    <= 8'h00;
      push_q     <= 1'b0;
      push_dat_q <= 8'h00;
    end else begin
      push_q <= 1'b0;
      if (ts_rise) begin
        if (!ts_vld) begin
          ts_act_q <= 1'b0;
          ts_cnt_q <= 3'd0;
        end else if (ts_syn) begin
          ts_act_q <= 1'b1;
          ts_cnt_q <= 3'd1;
          ts_sh_q  <= ts_first;
        end else if (ts_act_q) begin
          ts_sh_q  <= ts_cap;
          ts_cnt_q <= ts_cnt_q + 3'd1;
          if (ts_cnt_q == 3'd7) begin
            push_q     <= 1'b1;
            push_dat_q <= ts_cap;
          end
        end
      end
    end
  end

  // ---------------- Byte FIFO ----------------
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               fifo_empty, fifo_full, pop, push_ok, ovf_ev;
  logic [7:0]         head;

  logic               spi_bnd;
  spi_st_e            spi_st_q;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_LVL);
  assign head       = mem_q[rd_ptr_q];
  assign pop        = spi_bnd & ~fifo_empty;
  // Full plus a same-cycle pop frees the slot the push writes into
  assign push_ok    = push_q & (~fifo_full | pop);
  assign ovf_ev     = push_q & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
      else if (pop && !push_ok) cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
    end
  end

  // ---------------- Overflow status ----------------
  logic       ovf_q, clr_q;
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'h00;
    end else if (ovf_ev) begin
      ovf_q  <= 1'b1;
      drop_q <= clr_q ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
    end else if (clr_q) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'h00;
    end
  end

  // ---------------- SPI slave ----------------
  logic [31:0] lvl_ext;
  logic [7:0]  status;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_q, tx_q;
  logic [7:0]  rx_nxt;
  logic        miso_q, first_q, started_q;

  assign lvl_ext = 32'(cnt_q);
  assign status  = {ovf_q, fifo_empty, (lvl_ext > 32'd63) ? 6'd63 : lvl_ext[5:0]};
  assign rx_nxt  = {rx_q, mosi_s};
  // started_q guards against a stray falling edge before the first rising edge of a frame
  assign spi_bnd = (spi_st_q == SPI_XFER) & ~cs_rise & sck_fall & (bit_cnt_q == 3'd0) & started_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_st_q  <= SPI_IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      tx_q      <= 7'd0;
      miso_q    <= 1'b0;
      first_q   <= 1'b0;
      started_q <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      if (spi_st_q == SPI_IDLE) begin
        miso_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
        if (cs_fall) begin
          spi_st_q  <= SPI_XFER;
          tx_q      <= status[6:0];
          miso_q    <= status[7];
          first_q   <= 1'b1;
          started_q <= 1'b0;
        end
      end else if (cs_rise) begin
        spi_st_q  <= SPI_IDLE;
        miso_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
      end else begin
        if (sck_rise) begin
          rx_q      <= rx_nxt[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          started_q <= 1'b1;
          if (bit_cnt_q == 3'd7) begin
            first_q <= 1'b0;
            if (first_q && rx_nxt == CLR_CMD) clr_q <= 1'b1;
          end
        end
        if (sck_fall) begin
          if (spi_bnd) begin
            tx_q   <= fifo_empty ? 7'd0 : head[6:0];
            miso_q <= fifo_empty ? 1'b0 : head[7];
          end else begin
            tx_q   <= {tx_q[5:0], 1'b0};
            miso_q <= tx_q[6];
          end
        end
      end
    end
  end

  assign spi_miso   = miso_q;
  assign fifo_level = cnt_q;
  assign ovf_flag   = ovf_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_lgdst_ts_spi_bridge.sv
// Bench for lgdst_ts_spi_bridge: directed table, multi-cycle corner sequences, then randomized
// TS bursts and SPI reads checked against a queue-based reference model.
module tb_lgdst_ts_spi_bridge;

  localparam int TH = 4;
  localparam int SH = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ts_clk = 1'b0, ts_d0 = 1'b0, ts_valid = 1'b0, ts_sync = 1'b0;
  logic       spi_spck = 1'b0, spi_npcs0 = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso;
  logic [4:0] fifo_level;
  logic       ovf_flag;
  logic [7:0] drop_cnt;

  lgdst_ts_spi_bridge #(
    .FIFO_AW(4), .TS_MSB_FIRST(1'b0), .SYNC_STAGES(2), .CLR_CMD(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ts_clk(ts_clk), .ts_d0(ts_d0), .ts_valid(ts_valid), .ts_sync(ts_sync),
    .spi_spck(spi_spck), .spi_npcs0(spi_npcs0), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .fifo_level(fifo_level), .ovf_flag(ovf_flag), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] mq[$];
  logic       m_ovf;
  int         m_drop;
  logic [7:0] ts_q[$];
  logic [7:0] rx_b [8];

  typedef struct {
    int         op;       // 0 = TS burst of n bytes din, din+1, ...; 1 = SPI read of n bytes, first MOSI = din
    int         n;
    logic [7:0] din;
    logic [7:0] exp_m0;
    logic [7:0] exp_mr;
    int         exp_lvl;
    int         exp_ovf;
    int         exp_drop;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void m_push(input logic [7:0] b);
    if (mq.size() == 16) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end else begin
      mq.push_back(b);
    end
  endfunction

  function automatic logic [7:0] m_pop();
    if (mq.size() == 0) return 8'h00;
    return mq.pop_front();
  endfunction

  function automatic logic [7:0] m_status();
    int s;
    s = mq.size();
    return {m_ovf, (s == 0), 6'((s > 63) ? 63 : s)};
  endfunction

  task automatic ts_bit(input logic d, input logic v, input logic s);
    ts_d0 = d; ts_valid = v; ts_sync = s;
    repeat (TH) @(negedge clk);
    ts_clk = 1'b1;
    repeat (TH) @(negedge clk);
    ts_clk = 1'b0;
  endtask

  // Sends ts_q as one stream, LSB first, ts_sync only on the very first bit
  task automatic ts_send_q();
    logic [7:0] b;
    for (int j = 0; j < ts_q.size(); j++) begin
      b = ts_q[j];
      for (int i = 0; i < 8; i++) ts_bit(b[i], 1'b1, (j == 0 && i == 0));
    end
    ts_valid = 1'b0; ts_sync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] m, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int b = 7; b > 7 - nb; b--) begin
      spi_mosi = m[b];
      repeat (SH) @(negedge clk);
      r[b] = spi_miso;
      spi_spck = 1'b1;
      repeat (SH) @(negedge clk);
      spi_spck = 1'b0;
    end
  endtask

  task automatic spi_read(input int n, input logic [7:0] mosi0);
    logic [7:0] r, m;
    spi_npcs0 = 1'b0;
    repeat (SH) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      m = (k == 0) ? mosi0 : 8'($urandom);
      spi_byte(m, 8, r);
      rx_b[k] = r;
    end
    repeat (SH) @(negedge clk);
    spi_npcs0 = 1'b1;
    repeat (SH) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spi_npcs0 = 1'b1; spi_spck = 1'b0; ts_clk = 1'b0; ts_valid = 1'b0; ts_sync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mq.delete(); m_ovf = 1'b0; m_drop = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] exp_b [8];
    logic [7:0] mosi0;
    int         n;

    tbl[0] = '{0, 1,  8'h47, 8'h00, 8'h00, 1,  0, 0};
    tbl[1] = '{1, 2,  8'h00, 8'h01, 8'h47, 0,  0, 0};
    tbl[2] = '{1, 3,  8'h00, 8'h40, 8'h00, 0,  0, 0};
    tbl[3] = '{0, 18, 8'h10, 8'h00, 8'h00, 16, 1, 2};
    tbl[4] = '{1, 1,  8'h00, 8'h90, 8'h00, 15, 1, 2};
    tbl[5] = '{1, 2,  8'hA5, 8'h8F, 8'h11, 13, 0, 0};
    tbl[6] = '{1, 2,  8'h00, 8'h0D, 8'h13, 11, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.miso", 32'(spi_miso), 0);
    chk("rst.level", 32'(fifo_level), 0);
    chk("rst.ovf", 32'(ovf_flag), 0);
    chk("rst.drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].op == 0) begin
        ts_q.delete();
        for (int j = 0; j < tbl[i].n; j++) ts_q.push_back(tbl[i].din + 8'(j));
        ts_send_q();
      end else begin
        spi_read(tbl[i].n, tbl[i].din);
        chk($sformatf("tbl%0d.status", i), 32'(rx_b[0]), 32'(tbl[i].exp_m0));
        for (int k = 1; k < tbl[i].n; k++)
          chk($sformatf("tbl%0d.byte%0d", i, k), 32'(rx_b[k]), 32'(tbl[i].exp_mr));
      end
      chk($sformatf("tbl%0d.level", i), 32'(fifo_level), tbl[i].exp_lvl);
      chk($sformatf("tbl%0d.ovf", i), 32'(ovf_flag), tbl[i].exp_ovf);
      chk($sformatf("tbl%0d.drop", i), 32'(drop_cnt), tbl[i].exp_drop);
    end

    // Chip-select rise mid-byte: the popped byte is lost
    do_reset();
    ts_q.delete(); ts_q.push_back(8'h3C); ts_q.push_back(8'hC3);
    ts_send_q();
    spi_npcs0 = 1'b0;
    repeat (SH) @(negedge clk);
    spi_byte(8'h00, 8, r);
    chk("csrise.status", 32'(r), 32'h02);
    spi_byte(8'h00, 3, r);
    chk("csrise.partial", 32'(r), 32'h20);
    repeat (SH) @(negedge clk);
    spi_npcs0 = 1'b1;
    repeat (SH) @(negedge clk);
    chk("csrise.miso_idle", 32'(spi_miso), 0);
    chk("csrise.level", 32'(fifo_level), 1);
    spi_read(2, 8'h00);
    chk("csrise.status2", 32'(rx_b[0]), 32'h01);
    chk("csrise.next", 32'(rx_b[1]), 32'hC3);

    // No sync -> ignored; valid drop after 5 bits discards; new sync realigns
    do_reset();
    for (int i = 0; i < 8; i++) ts_bit(1'b1, 1'b1, 1'b0);
    ts_bit(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) ts_bit(1'b0, 1'b1, 1'b0);
    ts_bit(1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("tsdrop.level", 32'(fifo_level), 0);
    ts_q.delete(); ts_q.push_back(8'h5A);
    ts_send_q();
    chk("tsrealign.level", 32'(fifo_level), 1);
    spi_read(2, 8'h00);
    chk("tsrealign.status", 32'(rx_b[0]), 32'h01);
    chk("tsrealign.byte", 32'(rx_b[1]), 32'h5A);
    chk("tsrealign.level_after", 32'(fifo_level), 0);

    // Reset during the 4th SPI bit with 3 bytes queued
    do_reset();
    ts_q.delete(); ts_q.push_back(8'hF0); ts_q.push_back(8'h0F); ts_q.push_back(8'h81);
    ts_send_q();
    spi_npcs0 = 1'b0;
    repeat (SH) @(negedge clk);
    spi_byte(8'h00, 3, r);
    spi_mosi = 1'b0;
    repeat (SH) @(negedge clk);
    spi_spck = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst.level_before", 32'(fifo_level), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst.miso", 32'(spi_miso), 0);
    chk("midrst.level", 32'(fifo_level), 0);
    do_reset();
    chk("midrst.level_after", 32'(fifo_level), 0);

    // Randomized traffic against the queue model
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 6);
        ts_q.delete();
        for (int j = 0; j < n; j++) begin
          r = 8'($urandom);
          ts_q.push_back(r);
          m_push(r);
        end
        ts_send_q();
      end else begin
        n = $urandom_range(1, 4);
        mosi0 = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
        exp_b[0] = m_status();
        for (int k = 1; k < n; k++) exp_b[k] = m_pop();
        void'(m_pop());
        if (mosi0 == 8'hA5) begin
          m_ovf = 1'b0; m_drop = 0;
        end
        spi_read(n, mosi0);
        for (int k = 0; k < n; k++)
          chk($sformatf("rnd%0d.byte%0d", it, k), 32'(rx_b[k]), 32'(exp_b[k]));
      end
      chk($sformatf("rnd%0d.level", it), 32'(fifo_level), mq.size());
      chk($sformatf("rnd%0d.ovf", it), 32'(ovf_flag), 32'(m_ovf));
      chk($sformatf("rnd%0d.drop", it), 32'(drop_cnt), m_drop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lgdst_ts_spi_bridge.md
LGDST_TS_SPI_BRIDGE -- requirements
Module: lgdst_ts_spi_bridge

Interface
REQ-001 The block SHALL have exactly one clock and one reset: `clk` is the sole clock; `rst_n` is the reset, asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line: name, default, meaning.
  - FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW bytes.
  - TS_MSB_FIRST, 0, TS bit order: 0 = first serial bit lands in byte bit 0; 1 = first serial bit lands in byte bit 7.
  - SYNC_STAGES, 2, synchronizer flops per async input; minimum 2.
  - CLR_CMD, 8'hA5, MOSI command byte that clears overflow status.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  - clk, in, 1, system clock; all async inputs are oversampled on it.
  - rst_n, in, 1, async active-low reset.
  - ts_clk, in, 1, TS bit clock; async.
  - ts_d0, in, 1, TS serial data.
  - ts_valid, in, 1, TS valid.
  - ts_sync, in, 1, TS packet-start strobe.
  - spi_spck, in, 1, SPI host clock, mode 0; async.
  - spi_npcs0, in, 1, SPI chip select, active-low.
  - spi_mosi, in, 1, SPI host data.
  - spi_miso, out, 1, SPI slave data.
  - fifo_level, out, FIFO_AW+1, current byte count.
  - ovf_flag, out, 1, sticky overflow.
  - drop_cnt, out, 8, dropped-byte count; saturates at 255.

Function
REQ-004 Every async input SHALL pass through SYNC_STAGES flops on clk; rising and falling edges SHALL be derived from the last two stages only.
REQ-005 The TS deserializer SHALL act only on a synchronized ts_clk rising edge.
  - ts_valid=0: active cleared, bit counter cleared, partial byte discarded.
  - ts_valid=1 and ts_sync=1: active set; current bit captured as bit 0 of a new byte; counter=1.
  - ts_valid=1, active=1, ts_sync=0: bit captured; counter increments.
REQ-006 When the 8th bit is captured, the assembled byte SHALL be pushed on the next clk cycle and the counter SHALL wrap to 0 with active kept set; bit placement follows TS_MSB_FIRST.
REQ-007 FIFO push rules:
  - Push when full and no pop in the same cycle: byte dropped; ovf_flag set; drop_cnt incremented, saturating at 255.
  - Push and pop in the same cycle: both honored, including when full; fifo_level unchanged.
REQ-008 SPI framing:
  - Synchronized spi_npcs0 falling edge starts a transaction; byte index resets to 0.
  - Shift register loads the status byte: {ovf_flag, empty, min(fifo_level,63)[5:0]}.
  - spi_miso drives status bit 7 within 1 clk of the edge detection.
REQ-009 spi_miso SHALL update MSB-first on each synchronized spi_spck falling edge; the host samples on rising edges.
REQ-010 Each synchronized spi_spck rising edge SHALL shift spi_mosi into a receive register and increment an in-byte bit counter, mod 8.
REQ-011 At each byte boundary (8th falling edge) the shift register SHALL load the FIFO head and pop one entry; if the FIFO is empty it SHALL load 8'h00 with no pop.
REQ-012 When the first received MOSI byte equals CLR_CMD, ovf_flag and drop_cnt SHALL clear on the following clk cycle.
  - A simultaneous overflow event takes priority: flag stays set; count = 1.
REQ-013 A synchronized spi_npcs0 rising edge SHALL end the transaction:
  - spi_miso forced to 0; bit counter cleared.
  - An already-popped, partially shifted byte is lost and SHALL NOT be re-queued.
REQ-014 While spi_npcs0 is high, spi_miso SHALL be 0 and no pop SHALL occur.

Reset
REQ-015 While rst_n=0, and for all state, the following SHALL hold:
  - Outputs: spi_miso=0, fifo_level=0, ovf_flag=0, drop_cnt=0.
  - FIFO pointers=0; deserializer inactive; counters=0.
  - Synchronizer flops reset to inactive levels: spi_npcs0 chain=1, all other chains=0.
REQ-016 Reset asserted mid-transfer SHALL discard FIFO contents and the partial byte; after deassertion the block SHALL wait for a fresh ts_sync and a fresh spi_npcs0 fall.

Verification
REQ-017 TS 0x47 sent LSB-first with sync on first bit, TS_MSB_FIRST=0, then SPI read of 2 bytes -> MISO bytes = 0x01 (status, level 1), then 0x47; fifo_level returns to 0.
REQ-018 Depth 16: push 18 bytes with no reads -> fifo_level=16, ovf_flag=1, drop_cnt=2; next SPI status byte = 0x90.
REQ-019 SPI read with MOSI first byte 0xA5 after overflow -> ovf_flag=0, drop_cnt=0; FIFO contents intact, minus one byte popped at the first boundary.
REQ-020 SPI read of 3 bytes on an empty FIFO -> MISO = 0x40, 0x00, 0x00; fifo_level stays 0.
REQ-021 ts_valid dropped after 5 bits -> no push; a new ts_sync realigns, and the next full byte pushes correctly.
REQ-022 Two cases:
  - rst_n pulsed low during the 4th SPI bit with 3 bytes queued -> spi_miso=0 and fifo_level=0 immediately.
  - spi_npcs0 rise mid-byte -> popped byte not returned.
